// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: register offsets, STATUS bit
// positions, receive FSM states and the baud divisor clamp.
package uart_rx_pkg;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;
  localparam logic [1:0] RegDiv    = 2'd3;

  // STATUS bit positions
  localparam int unsigned StatNempty   = 0;
  localparam int unsigned StatFull     = 1;
  localparam int unsigned StatOvr      = 2;
  localparam int unsigned StatFerr     = 3;
  localparam int unsigned StatCountLsb = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBrk
  } rx_state_e;

  // Divisors below 2 cannot give a distinct mid-bit sample point
  function automatic logic [15:0] div_clamp(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. Simultaneous push and pop is supported in every
// state, including full; a push into a full FIFO without a pop is dropped and
// a pop from an empty FIFO is ignored.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot this push needs
  assign do_push = push & (~full | do_pop);

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive half: 8N1 deserialiser with programmable divisor, receive FIFO
// and a small register file (DATA/STATUS/CTRL/DIV) on the peripheral bus.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [3:0]  lane,
  input  logic        wr,
  input  logic        valid,
  input  logic        rxd,
  output logic        rx_irq
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DivRst = 16'(CLK_HZ / BAUD);

  logic            rxd_meta_q, rxd_sync_q;
  logic            valid_q, acc, acc_rd, acc_wr;
  logic [1:0]      reg_sel;
  logic [31:0]     rd_data;
  logic            ie_q, ovr_q, ferr_q;
  logic [15:0]     div_q, div_eff;
  logic            ovr_set, ovr_clr, ferr_set, ferr_clr;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic [4:0]      count5;
  rx_state_e       state_q, state_d;
  logic [15:0]     cnt_q, cnt_d, div_act_q, div_act_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], din[31:16], lane[3:2]};

  assign reg_sel  = addr[3:2];
  assign acc      = valid & ~valid_q;
  assign acc_rd   = acc & ~wr;
  assign acc_wr   = acc & wr;
  assign div_eff  = div_clamp(div_q);
  assign count5   = 5'(fifo_count);
  assign fifo_pop = acc_rd & (reg_sel == RegData) & ~fifo_empty;
  assign ovr_set  = fifo_push & fifo_full & ~fifo_pop;
  assign ovr_clr  = acc_wr & (reg_sel == RegStatus) & lane[0] & din[StatOvr];
  assign ferr_clr = acc_wr & (reg_sel == RegStatus) & lane[0] & din[StatFerr];

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (shift_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Two-flop synchroniser for the asynchronous serial input (idles high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Read data mux for the addressed register
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      RegData: begin
        if (!fifo_empty) rd_data = {23'd0, 1'b1, fifo_rdata};
      end
      RegStatus: begin
        rd_data[StatCountLsb +: 5] = count5;
        rd_data[StatFerr]          = ferr_q;
        rd_data[StatOvr]           = ovr_q;
        rd_data[StatFull]          = fifo_full;
        rd_data[StatNempty]        = ~fifo_empty;
      end
      RegCtrl: rd_data[0]    = ie_q;
      default: rd_data[15:0] = div_q;
    endcase
  end

  // Bus side: access edge detect, registered read data, CTRL/DIV writes.
  // Writes return zero on dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dout    <= '0;
      ie_q    <= 1'b0;
      div_q   <= DivRst;
    end else begin
      valid_q <= valid;
      if (acc) dout <= wr ? '0 : rd_data;
      if (acc_wr && reg_sel == RegCtrl && lane[0]) ie_q <= din[0];
      if (acc_wr && reg_sel == RegDiv) begin
        if (lane[0]) div_q[7:0]  <= din[7:0];
        if (lane[1]) div_q[15:8] <= din[15:8];
      end
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~ovr_clr);
      ferr_q <= ferr_set | (ferr_q & ~ferr_clr);
    end
  end

  // Interrupt follows the FIFO state one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_irq <= 1'b0;
    else     rx_irq <= ie_q & ~fifo_empty;
  end

  // Receive FSM and baud/bit counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_act_q <= DivRst;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  // Next state: the divisor is captured at the start edge so a DIV write
  // never disturbs a frame in flight
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_push = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxd_sync_q) begin
          state_d   = StStart;
          div_act_d = div_eff;
          cnt_d     = (div_eff >> 1) - 16'd1;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (rxd_sync_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = div_act_q - 16'd1;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d = {rxd_sync_q, shift_q[7:1]};
          cnt_d   = div_act_q - 16'd1;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (rxd_sync_q) begin
            fifo_push = 1'b1;
            state_d   = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StBrk;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StBrk: begin
        if (rxd_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level serial stimulus with a queue-based model of
// the receive FIFO and register file, checked every cycle against dout/rx_irq.
module tb_uart_rx;

  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din, dout;
  logic [3:0]  lane;
  logic        wr, valid, rxd, rx_irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0]  m_q[$];
  logic        m_ie, m_ovr, m_ferr;
  logic [15:0] m_div;
  logic [31:0] exp_dout;
  logic        irq_model;
  logic        chk_en  = 1'b0;
  logic        irq_chk = 1'b0;

  uart_rx #(
    .CLK_HZ     (50_000_000),
    .BAUD       (115200),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .lane   (lane),
    .wr     (wr),
    .valid  (valid),
    .rxd    (rxd),
    .rx_irq (rx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    int n = m_q.size();
    return {19'd0, 5'(n), 4'd0, m_ferr, m_ovr, n == Depth, n != 0};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ie     = 1'b0;
    m_ovr    = 1'b0;
    m_ferr   = 1'b0;
    m_div    = 16'd434;
    exp_dout = '0;
  endtask

  // Interrupt is IE & non-empty, seen one clock later
  always @(posedge clk or posedge rst) begin
    if (rst) irq_model <= 1'b0;
    else     irq_model <= m_ie && (m_q.size() != 0);
  end

  // Continuous output comparison
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("dout", dout, exp_dout);
      if (irq_chk) chk("rx_irq", {31'd0, rx_irq}, {31'd0, irq_model});
    end
  end

  task automatic model_access(input bit w, input logic [1:0] a, input logic [31:0] d,
                              input logic [3:0] ln);
    if (w) begin
      exp_dout = '0;
      case (a)
        2'd1: if (ln[0]) begin
          if (d[2]) m_ovr  = 1'b0;
          if (d[3]) m_ferr = 1'b0;
        end
        2'd2: if (ln[0]) m_ie = d[0];
        2'd3: begin
          if (ln[0]) m_div[7:0]  = d[7:0];
          if (ln[1]) m_div[15:8] = d[15:8];
        end
        default: ;
      endcase
    end else begin
      case (a)
        2'd0: exp_dout = (m_q.size() != 0) ? {23'd0, 1'b1, m_q.pop_front()} : 32'd0;
        2'd1: exp_dout = status_exp();
        2'd2: exp_dout = {31'd0, m_ie};
        default: exp_dout = {16'd0, m_div};
      endcase
    end
  endtask

  task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] ln, output logic [31:0] rd);
    @(posedge clk); #1;
    valid = 1'b1; wr = w; addr = 32'h1000_0000 | {28'd0, a, 2'b00}; din = d; lane = ln;
    @(posedge clk); #1;
    model_access(w, a, d, ln);
    rd = dout;
    @(posedge clk); #1;
    valid = 1'b0; wr = 1'b0; din = '0; lane = '0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] rd);
    bus(1'b0, a, 32'd0, 4'h0, rd);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input logic [3:0] ln);
    logic [31:0] unused_rd;
    bus(1'b1, a, d, ln, unused_rd);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; the model is updated once the frame is over
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    int div = (m_div < 16'd2) ? 2 : int'(m_div);
    irq_chk = 1'b0;
    @(posedge clk); #1;
    rxd = 1'b0;
    hold(div);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold(div);
    end
    rxd = stop_ok;
    hold(div);
    rxd = 1'b1;
    hold(stop_ok ? 4 : div);
    if (!stop_ok)                m_ferr = 1'b1;
    else if (m_q.size() < Depth) m_q.push_back(b);
    else                         m_ovr = 1'b1;
    hold(3);
    irq_chk = 1'b1;
  endtask

  logic [31:0] rd;
  logic [7:0]  b;

  initial begin
    rst = 1'b1; rxd = 1'b1; valid = 1'b0; wr = 1'b0; addr = '0; din = '0; lane = '0;
    model_reset();
    hold(3);
    rst = 1'b0;
    chk_en = 1'b1; irq_chk = 1'b1;

    // Reset state
    chk("rst_dout", dout, 32'd0);
    chk("rst_irq", {31'd0, rx_irq}, 32'd0);
    rd_reg(2'd1, rd); chk("rst_status", rd, 32'd0);
    rd_reg(2'd3, rd); chk("rst_div", rd, 32'd434);

    // 0xA5 at the reset divisor
    send_frame(8'hA5, 1'b1);
    rd_reg(2'd0, rd); chk("a5_data", rd, 32'h0000_01A5);
    rd_reg(2'd1, rd); chk("a5_status", rd, 32'd0);
    rd_reg(2'd0, rd); chk("a5_empty", rd, 32'd0);

    // 0.3-bit glitch on idle line
    irq_chk = 1'b0;
    rxd = 1'b0; hold(130); rxd = 1'b1; hold(1000);
    irq_chk = 1'b1;
    rd_reg(2'd1, rd); chk("glitch_status", rd, 32'd0);

    // Framing error, then W1C
    send_frame(8'h3C, 1'b0);
    rd_reg(2'd1, rd); chk("ferr_status", rd, 32'h0000_0008);
    wr_reg(2'd1, 32'h8, 4'h1);
    rd_reg(2'd1, rd); chk("ferr_clear", rd, 32'd0);

    // Overflow: 17 frames into a 16-entry FIFO
    wr_reg(2'd3, 32'd40, 4'h3);
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    rd_reg(2'd1, rd); chk("ovr_status", rd, 32'h0000_1007);
    for (int i = 0; i < 16; i++) begin
      rd_reg(2'd0, rd); chk("ovr_data", rd, 32'h100 | i);
    end
    rd_reg(2'd1, rd); chk("ovr_after", rd, 32'h0000_0004);
    wr_reg(2'd1, 32'h4, 4'h1);
    rd_reg(2'd1, rd); chk("ovr_clear", rd, 32'd0);

    // Interrupt
    wr_reg(2'd2, 32'h1, 4'h1);
    send_frame(8'h55, 1'b1);
    chk("irq_set", {31'd0, rx_irq}, 32'd1);
    rd_reg(2'd0, rd); chk("irq_data", rd, 32'h0000_0155);
    chk("irq_clr", {31'd0, rx_irq}, 32'd0);

    // Faster baud
    wr_reg(2'd3, 32'd217, 4'h3);
    b = 8'($urandom);
    send_frame(b, 1'b1);
    rd_reg(2'd0, rd); chk("div217_data", rd, {23'd0, 1'b1, b});

    // Reset in the middle of the data bits
    irq_chk = 1'b0;
    @(posedge clk); #1;
    rxd = 1'b0; hold(217 * 3);
    rxd = 1'b1;
    rst = 1'b1;
    model_reset();
    hold(3);
    rst = 1'b0;
    irq_chk = 1'b1;
    rd_reg(2'd1, rd); chk("mid_rst_status", rd, 32'd0);
    rd_reg(2'd2, rd); chk("mid_rst_ctrl", rd, 32'd0);
    rd_reg(2'd3, rd); chk("mid_rst_div", rd, 32'd434);
    rd_reg(2'd0, rd); chk("mid_rst_data", rd, 32'd0);

    // Randomised frames, divisors and register traffic
    wr_reg(2'd2, 32'h1, 4'h1);
    wr_reg(2'd3, 32'(16 + $urandom_range(48)), 4'h3);
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(3) == 0) wr_reg(2'd3, 32'(16 + $urandom_range(48)), 4'h3);
      send_frame(8'($urandom), $urandom_range(9) != 0);
      case ($urandom_range(3))
        0: rd_reg(2'd0, rd);
        1: rd_reg(2'd1, rd);
        2: wr_reg(2'd1, {28'd0, 2'($urandom), 2'd0}, 4'h1);
        default: ;
      endcase
    end
    rd_reg(2'd1, rd);
    for (int i = 0; i < 16; i++) rd_reg(2'd0, rd);
    rd_reg(2'd1, rd);
    hold(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
